// File: rtl/mux32_sched_pkg.sv
// Shared types and helpers for the shared 32:1 mux round-robin scheduler.
// The MUX32_SCHED_LOCK_EN macro is consumed by the top, not here.
package mux32_sched_pkg;

    localparam int unsigned SEL_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEL   = 2'd1,
        ST_VALID = 2'd2
    } sched_state_t;

    // Reference round-robin search over the low n bits of req; returns {found, idx}.
    function automatic logic [5:0] next_rr(input logic [31:0] req,
                                           input logic [4:0]  ptr,
                                           input int unsigned n);
        logic        found;
        logic [4:0]  idx;
        int unsigned c;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < n; k++) begin
            c = int'(ptr) + k;
            if (c >= n) c = c - n;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = 5'(c);
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/mux32_rr_scheduler_rr_pick.sv
// Combinational rotate-priority finder: first set req at index >= ptr, wrapping N-1 -> 0.
module rr_pick
    import mux32_sched_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned SEL_W = SEL_W_DEF
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [2*N-1:0] dbl;
    int unsigned    pos;

    assign dbl = {req, req};

    // Window [ptr, ptr+N) of the doubled vector covers one full rotation.
    always_comb begin
        found = 1'b0;
        pos   = 0;
        for (int unsigned j = 0; j < 2 * N; j++) begin
            if (!found && dbl[j] && (j >= int'(ptr)) && (j < int'(ptr) + N)) begin
                found = 1'b1;
                pos   = j;
            end
        end
        idx = SEL_W'((pos >= N) ? (pos - N) : pos);
    end

endmodule

// File: rtl/mux32_rr_scheduler.sv
// Round-robin scheduler sharing one external 32:1 bit mux between N requesters.
// Optional MUX32_SCHED_LOCK_EN adds a lock input that re-arms the served channel.
module mux32_rr_scheduler
    import mux32_sched_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [SEL_W-1:0] sel,
    input  logic             mux_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic [SEL_W-1:0] out_chan,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     ack,
`ifdef MUX32_SCHED_LOCK_EN
    input  logic             lock,
`endif
    output logic             busy
);

    sched_state_t     state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_adv;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef MUX32_SCHED_LOCK_EN
    assign ptr_adv = lock ? out_chan
                   : ((out_chan == SEL_W'(N - 1)) ? '0 : out_chan + 1'b1);
`else
    assign ptr_adv = (out_chan == SEL_W'(N - 1)) ? '0 : out_chan + 1'b1;
`endif

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            sel       <= '0;
            gnt       <= '0;
            ack       <= '0;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            out_chan  <= '0;
        end else begin
            ack <= '0;
            case (state)
                // The ack cycle is spent idle so each grant takes four cycles.
                ST_IDLE: begin
                    if (pick_found && (ack == '0)) begin
                        sel   <= pick_idx;
                        gnt   <= N'(1) << pick_idx;
                        state <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    out_data  <= mux_out;
                    out_chan  <= sel;
                    out_valid <= 1'b1;
                    state     <= ST_VALID;
                end
                ST_VALID: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        gnt       <= '0;
                        ack       <= gnt;
                        ptr       <= ptr_adv;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux32_rr_scheduler.sv
// Directed self-checking bench for mux32_rr_scheduler (N=32) with an ideal 32:1 mux model.
module tb_mux32_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req = '0;
    logic [4:0]  sel;
    logic        mux_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_data;
    logic [4:0]  out_chan;
    logic [31:0] gnt;
    logic [31:0] ack;
    logic        lock = 1'b0;
    logic        busy;
    logic [31:0] mux_a = '0;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    assign mux_out = mux_a[sel];

    mux32_rr_scheduler #(.N(32), .SEL_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .sel       (sel),
        .mux_out   (mux_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .gnt       (gnt),
        .ack       (ack),
`ifdef MUX32_SCHED_LOCK_EN
        .lock      (lock),
`endif
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!out_valid && cnt < 20);
        check("valid_seen", 64'(out_valid), 64'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] pat;
        logic        exp_bit;

        // Reset values
        tick();
        tick();
        check("rst_sel",   64'(sel),       64'(0));
        check("rst_gnt",   64'(gnt),       64'(0));
        check("rst_ack",   64'(ack),       64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_data",  64'(out_data),  64'(0));
        check("rst_chan",  64'(out_chan),  64'(0));
        check("rst_busy",  64'(busy),      64'(0));
        rst = 1'b0;

        // Single request on channel 4
        req       = 32'h0000_0010;
        mux_a     = 32'h0000_0010;
        out_ready = 1'b1;
        tick();
        check("single_sel",    64'(sel),       64'(4));
        check("single_gnt",    64'(gnt),       64'h10);
        check("single_nvalid", 64'(out_valid), 64'(0));
        check("single_busy",   64'(busy),      64'(1));
        tick();
        check("single_valid",  64'(out_valid), 64'(1));
        check("single_data",   64'(out_data),  64'(1));
        check("single_chan",   64'(out_chan),  64'(4));
        tick();
        check("single_ack",    64'(ack),       64'h10);
        check("single_vdrop",  64'(out_valid), 64'(0));
        check("single_gdrop",  64'(gnt),       64'(0));
        req = '0;
        tick();
        check("single_ack1",   64'(ack),       64'(0));
        check("single_idle",   64'(busy),      64'(0));

        // All-request fairness from ptr=0
        do_reset();
        pat       = 32'hA5C3_0F96;
        mux_a     = pat;
        req       = '1;
        out_ready = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            wait_valid(n);
            exp_bit = pat[k % 32];
            check("rr_chan",    64'(out_chan), 64'(k % 32));
            check("rr_data",    64'(out_data), 64'(exp_bit));
            check("rr_spacing", 64'(n),        64'((k == 0) ? 2 : 4));
        end
        req = '0;
        tick();
        check("rr_withdraw_ack", 64'(ack), 64'h1);
        tick();

        // Wrap-around: ch30, then ch31 and ch0
        do_reset();
        req = 32'h4000_0000;
        wait_valid(n);
        check("wrap_ch30", 64'(out_chan), 64'(30));
        tick();
        check("wrap_ack30", 64'(ack), 64'h4000_0000);
        req = 32'h8000_0001;
        wait_valid(n);
        check("wrap_ch31", 64'(out_chan), 64'(31));
        tick();
        check("wrap_ack31", 64'(ack), 64'h8000_0000);
        req = 32'h0000_0001;
        wait_valid(n);
        check("wrap_ch0", 64'(out_chan), 64'(0));
        tick();
        req = '0;
        check("wrap_ack0", 64'(ack), 64'h1);
        tick();

        // Backpressure on channel 7
        req       = 32'h0000_0080;
        mux_a     = 32'h0000_0080;
        out_ready = 1'b0;
        wait_valid(n);
        check("bp_chan", 64'(out_chan), 64'(7));
        check("bp_data", 64'(out_data), 64'(1));
        mux_a = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_hold_valid", 64'(out_valid), 64'(1));
            check("bp_hold_data",  64'(out_data),  64'(1));
            check("bp_hold_sel",   64'(sel),       64'(7));
        end
        check("bp_no_ack", 64'(ack), 64'(0));
        out_ready = 1'b1;
        tick();
        check("bp_ack",    64'(ack),       64'h80);
        check("bp_vdrop",  64'(out_valid), 64'(0));
        req = '0;
        tick();
        check("bp_ack_end", 64'(ack), 64'(0));

        // Asynchronous reset mid-transaction, then ptr must restart at 0
        req       = 32'h0000_0008;
        out_ready = 1'b0;
        wait_valid(n);
        check("mid_chan", 64'(out_chan), 64'(3));
        #2 rst = 1'b1;
        #1;
        check("mid_valid", 64'(out_valid), 64'(0));
        check("mid_gnt",   64'(gnt),       64'(0));
        check("mid_ack",   64'(ack),       64'(0));
        check("mid_sel",   64'(sel),       64'(0));
        check("mid_busy",  64'(busy),      64'(0));
        tick();
        rst       = 1'b0;
        req       = 32'h0000_0104;
        out_ready = 1'b1;
        wait_valid(n);
        check("mid_ptr0", 64'(out_chan), 64'(2));
        tick();
        req = '0;
        tick();

`ifdef MUX32_SCHED_LOCK_EN
        // Lock keeps channel 1 winning; releasing it lets channel 2 in
        do_reset();
        lock      = 1'b1;
        req       = 32'h0000_0006;
        out_ready = 1'b1;
        wait_valid(n);
        check("lock_first", 64'(out_chan), 64'(1));
        tick();
        check("lock_ack", 64'(ack), 64'h2);
        wait_valid(n);
        check("lock_again", 64'(out_chan), 64'(1));
        lock = 1'b0;
        tick();
        wait_valid(n);
        check("lock_release", 64'(out_chan), 64'(2));
        req = '0;
        tick();
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
